// File: rtl/block_xfer_sequencer.sv
// Block-transfer micro-sequencer: expands LDM/STM into one load/store
// micro-op per listed register (ascending index) plus an optional base
// writeback micro-op, holding decode via Busy until the last one is consumed.
module block_xfer_sequencer #(
    parameter int REG_COUNT  = 16,
    parameter int IDX_W      = 4,
    parameter int WORD_BYTES = 4,
    parameter int OFF_W      = IDX_W + 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             InstrValid,
    input  logic             Stall,
    output logic             IsBlock,
    output logic             Busy,
    output logic             UopValid,
    output logic             UopLoad,
    output logic [IDX_W-1:0] UopRd,
    output logic [IDX_W-1:0] UopRn,
    output logic [OFF_W-1:0] UopOffset,
    output logic             UopWB
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WB
    } state_t;

    state_t                 state_q, state_d;

    // Sequence context captured at accept
    logic                   p_q, u_q;
    logic [IDX_W-1:0]       rn_q;
    logic [IDX_W:0]         n_q;
    logic                   wb_en_q;
    // Registers still to be emitted (excludes the one currently presented)
    logic [REG_COUNT-1:0]   rem_q;
    // Ordinal of the next transfer micro-op to be emitted
    logic [IDX_W:0]         k_q;

    logic [REG_COUNT-1:0]   list_in;
    logic [IDX_W-1:0]       rn_in;
    logic [IDX_W:0]         n_in;
    logic                   accept;
    logic                   last_xfer;
    logic                   final_uop;
    logic [OFF_W-1:0]       wb_mag;
    logic [OFF_W-1:0]       wb_off;
    logic                   unused_bits;

    // Index of the lowest set bit; ascending transfer order
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [REG_COUNT-1:0] mask);
        lowest_idx = '0;
        for (int unsigned i = REG_COUNT; i > 0; i--) begin
            if (mask[i-1]) lowest_idx = IDX_W'(i - 1);
        end
    endfunction

    function automatic logic [IDX_W:0] popcnt(input logic [REG_COUNT-1:0] mask);
        popcnt = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            popcnt = popcnt + {{IDX_W{1'b0}}, mask[i]};
        end
    endfunction

    // Byte offset of the idx-th transfer; modular arithmetic yields the
    // two's-complement result directly for the decrementing modes
    function automatic logic [OFF_W-1:0] xfer_off(input logic [IDX_W:0] idx,
                                                  input logic [IDX_W:0] cnt,
                                                  input logic p, input logic u);
        logic [OFF_W-1:0] i_e, n_e, base;
        i_e = OFF_W'(idx);
        n_e = OFF_W'(cnt);
        if (u) base = p ? (i_e + OFF_W'(1)) : i_e;
        else   base = p ? (i_e - n_e) : (i_e - n_e + OFF_W'(1));
        xfer_off = base * OFF_W'(WORD_BYTES);
    endfunction

    assign IsBlock     = InstrValid & (Instr[27:26] == 2'b10) & ~Instr[25];
    assign unused_bits = ^{Instr[31:28], Instr[22]};

    // Next state, accept, and Busy handshake toward the hazard unit
    always_comb begin
        list_in   = Instr[REG_COUNT-1:0];
        rn_in     = Instr[16 +: IDX_W];
        n_in      = popcnt(list_in);
        accept    = (state_q == S_IDLE) & IsBlock & ~Stall & (list_in != '0);
        last_xfer = (rem_q == '0);
        final_uop = (state_q == S_WB) | ((state_q == S_XFER) & last_xfer & ~wb_en_q);
        Busy      = accept | ((state_q != S_IDLE) & ~(final_uop & ~Stall));
        wb_mag    = OFF_W'(n_q) * OFF_W'(WORD_BYTES);
        wb_off    = u_q ? wb_mag : ('0 - wb_mag);
        state_d   = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_XFER;
            S_XFER:  if (~Stall & last_xfer) state_d = wb_en_q ? S_WB : S_IDLE;
            S_WB:    if (~Stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Micro-op output registers and sequence context; all hold under Stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= 1'b0;
            u_q       <= 1'b0;
            rn_q      <= '0;
            n_q       <= '0;
            wb_en_q   <= 1'b0;
            rem_q     <= '0;
            k_q       <= '0;
            UopValid  <= 1'b0;
            UopWB     <= 1'b0;
            UopLoad   <= 1'b0;
            UopRd     <= '0;
            UopRn     <= '0;
            UopOffset <= '0;
        end else if (accept) begin
            p_q       <= Instr[24];
            u_q       <= Instr[23];
            rn_q      <= rn_in;
            n_q       <= n_in;
            wb_en_q   <= Instr[21] & ~(Instr[20] & list_in[rn_in]);
            rem_q     <= list_in & (list_in - REG_COUNT'(1));
            k_q       <= (IDX_W+1)'(1);
            UopValid  <= 1'b1;
            UopWB     <= 1'b0;
            UopLoad   <= Instr[20];
            UopRd     <= lowest_idx(list_in);
            UopRn     <= rn_in;
            UopOffset <= xfer_off('0, n_in, Instr[24], Instr[23]);
        end else if (~Stall) begin
            case (state_q)
                S_XFER: begin
                    if (~last_xfer) begin
                        UopRd     <= lowest_idx(rem_q);
                        UopOffset <= xfer_off(k_q, n_q, p_q, u_q);
                        rem_q     <= rem_q & (rem_q - REG_COUNT'(1));
                        k_q       <= k_q + (IDX_W+1)'(1);
                    end else if (wb_en_q) begin
                        UopWB     <= 1'b1;
                        UopRd     <= rn_q;
                        UopOffset <= wb_off;
                    end else begin
                        UopValid  <= 1'b0;
                    end
                end
                S_WB: begin
                    UopValid <= 1'b0;
                    UopWB    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
